// File: rtl/window_gen_3x3_pkg.sv
// rtl/window_gen_3x3_pkg.sv - shared defaults and 3x3 window index constants
package window_gen_3x3_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int LINE_W_DEF = 640;
  localparam int ROW_W_DEF  = 12;

  localparam int WIN_ROW_TOP    = 0;
  localparam int WIN_ROW_MID    = 1;
  localparam int WIN_ROW_BOT    = 2;
  localparam int WIN_COL_LEFT   = 0;
  localparam int WIN_COL_CENTRE = 1;
  localparam int WIN_COL_RIGHT  = 2;

  // Flat index into w0..w8: row-major, oldest row first.
  function automatic int win_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - shift-on-enable delay line, DEPTH accepted samples deep
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Oldest entry: the sample accepted DEPTH writes before the current one.
  assign data_out = mem[DEPTH-1];

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster-stream 3x3 sliding window with row/column validity
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int ROW_W  = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] data_in,
  output logic [PIX_W-1:0] w0,
  output logic [PIX_W-1:0] w1,
  output logic [PIX_W-1:0] w2,
  output logic [PIX_W-1:0] w3,
  output logic [PIX_W-1:0] w4,
  output logic [PIX_W-1:0] w5,
  output logic [PIX_W-1:0] w6,
  output logic [PIX_W-1:0] w7,
  output logic [PIX_W-1:0] w8,
  output logic             out_valid
);

  localparam int COL_W = $clog2(LINE_W);

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic             last_col, row_max;
  logic [PIX_W-1:0] lb1_out, lb2_out;
  logic [PIX_W-1:0] win [9];

  line_buffer #(.WIDTH(PIX_W), .DEPTH(LINE_W)) u_lb1 (
    .clk      (clk),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (lb1_out)
  );

  line_buffer #(.WIDTH(PIX_W), .DEPTH(LINE_W)) u_lb2 (
    .clk      (clk),
    .write_en (write_en),
    .data_in  (lb1_out),
    .data_out (lb2_out)
  );

  // Position of the pixel on data_in; frame_start overrides the counters.
  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    last_col = (cur_col == COL_W'(LINE_W - 1));
    row_max  = &cur_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      win       <= '{default: '0};
    end else begin
      out_valid <= write_en && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      if (write_en) begin
        col <= last_col ? '0 : cur_col + COL_W'(1);
        row <= (last_col && !row_max) ? cur_row + ROW_W'(1) : cur_row;

        win[win_idx(WIN_ROW_TOP, WIN_COL_LEFT)]   <= win[win_idx(WIN_ROW_TOP, WIN_COL_CENTRE)];
        win[win_idx(WIN_ROW_TOP, WIN_COL_CENTRE)] <= win[win_idx(WIN_ROW_TOP, WIN_COL_RIGHT)];
        win[win_idx(WIN_ROW_TOP, WIN_COL_RIGHT)]  <= lb2_out;
        win[win_idx(WIN_ROW_MID, WIN_COL_LEFT)]   <= win[win_idx(WIN_ROW_MID, WIN_COL_CENTRE)];
        win[win_idx(WIN_ROW_MID, WIN_COL_CENTRE)] <= win[win_idx(WIN_ROW_MID, WIN_COL_RIGHT)];
        win[win_idx(WIN_ROW_MID, WIN_COL_RIGHT)]  <= lb1_out;
        win[win_idx(WIN_ROW_BOT, WIN_COL_LEFT)]   <= win[win_idx(WIN_ROW_BOT, WIN_COL_CENTRE)];
        win[win_idx(WIN_ROW_BOT, WIN_COL_CENTRE)] <= win[win_idx(WIN_ROW_BOT, WIN_COL_RIGHT)];
        win[win_idx(WIN_ROW_BOT, WIN_COL_RIGHT)]  <= data_in;
      end
    end
  end

  assign w0 = win[0];
  assign w1 = win[1];
  assign w2 = win[2];
  assign w3 = win[3];
  assign w4 = win[4];
  assign w5 = win[5];
  assign w6 = win[6];
  assign w7 = win[7];
  assign w8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - directed and randomized bench for window_gen_3x3 against a history-based model
module tb_window_gen_3x3;

  localparam int L    = 8;
  localparam int RW   = 3;
  localparam int RMAX = (1 << RW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic       frame_start;
  logic [7:0] data_in;
  logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       out_valid;
  logic [7:0] w [9];

  window_gen_3x3 #(.PIX_W(8), .LINE_W(L), .ROW_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .frame_start (frame_start),
    .data_in     (data_in),
    .w0          (w0),
    .w1          (w1),
    .w2          (w2),
    .w3          (w3),
    .w4          (w4),
    .w5          (w5),
    .w6          (w6),
    .w7          (w7),
    .w8          (w8),
    .out_valid   (out_valid)
  );

  assign w[0] = w0; assign w[1] = w1; assign w[2] = w2;
  assign w[3] = w3; assign w[4] = w4; assign w[5] = w5;
  assign w[6] = w6; assign w[7] = w7; assign w[8] = w8;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: every accepted pixel ever, plus the raster position of the next one.
  int hist [$];
  int m_col, m_row;
  int exp_win [9];
  int exp_valid;
  int win_known;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_col     = 0;
    m_row     = 0;
    exp_valid = 0;
    win_known = 1;
    for (int i = 0; i < 9; i++) exp_win[i] = 0;
  endtask

  task automatic model_accept(input logic fs, input int d);
    int c, r, n;
    c = fs ? 0 : m_col;
    r = fs ? 0 : m_row;
    hist.push_back(d);
    n = hist.size() - 1;
    exp_valid = (r >= 2 && c >= 2) ? 1 : 0;
    win_known = exp_valid;
    if (exp_valid != 0)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[3*i + j] = hist[n - (2 - i) * L - (2 - j)];
    if (c == L - 1) begin
      m_col = 0;
      m_row = (r == RMAX) ? r : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, int'(out_valid), exp_valid);
    if (win_known != 0)
      for (int i = 0; i < 9; i++) check($sformatf("%s_w%0d", tag, i), int'(w[i]), exp_win[i]);
  endtask

  task automatic check_win(input string tag, input int e [9]);
    for (int i = 0; i < 9; i++) check($sformatf("%s_w%0d", tag, i), int'(w[i]), e[i]);
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input logic we, input logic fs, input int d);
    write_en    = we;
    frame_start = fs;
    data_in     = d[7:0];
    @(posedge clk);
    if (we) model_accept(fs, d & 255);
    else exp_valid = 0;
    #5;
    check_outputs(we ? "pix" : "stall");
  endtask

  task automatic do_reset_async();
    write_en    = 1'b0;
    frame_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    write_en    = 1'b0;
    frame_start = 1'b0;
    data_in     = '0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= 20; i++) begin
      step(1'b1, i == 0, i);
      if (i == 18) begin
        check("first_valid", int'(out_valid), 1);
        check_win("p18", '{0, 1, 2, 8, 9, 10, 16, 17, 18});
      end
    end
    repeat (3) step(1'b0, 1'b0, 0);
    check_win("stall_hold", '{2, 3, 4, 10, 11, 12, 18, 19, 20});
    for (int i = 21; i <= 30; i++) begin
      step(1'b1, 1'b0, i);
      if (i == 21) check("w8_resume", int'(w8), 21);
      if (i == 24 || i == 25) check($sformatf("wrap_p%0d", i), int'(out_valid), 0);
      if (i == 26) check_win("p26", '{8, 9, 10, 16, 17, 18, 24, 25, 26});
    end

    do_reset_async();
    for (int i = 0; i <= 36; i++) begin
      step(1'b1, 1'b0, 100 + i);
      if (i == 18) check_win("p118", '{100, 101, 102, 108, 109, 110, 116, 117, 118});
    end
    for (int k = 0; k <= 18; k++) begin
      step(1'b1, k == 0, 200 + k);
      if (k == 18) check_win("p218", '{200, 201, 202, 208, 209, 210, 216, 217, 218});
    end

    // Long random run: rare frame_start lets the row counter reach saturation.
    repeat (900) begin
      if ($urandom_range(0, 299) == 0) do_reset_async();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, int'($urandom_range(0, 255)));
    end

    write_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
